// File: rtl/randomizer_pkg.sv
// Shared constants and the single-step LFSR function for the parallel randomizer.
// The step function works on a 32-bit container so one body serves every LFSR width.
package randomizer_pkg;

    typedef logic [14:0] pn15_t;

    localparam pn15_t PN15_TAPS = 15'h0003;
    localparam pn15_t SEED_DVB  = 15'h4A80;

    // One serial step: feedback enters at bit width-1, so the returned top bit is the PN bit.
    function automatic logic [31:0] lfsr_step(input logic [31:0] state,
                                              input logic [31:0] taps,
                                              input int          width);
        logic fb;
        fb = ^(state & taps);
        return (state >> 1) | ({31'd0, fb} << (width - 1));
    endfunction

endpackage

// File: rtl/randomizer_par_lfsr_unroll.sv
// Combinational DATA_W-step LFSR advance; pn[i] is the feedback bit of step i in time order.
module lfsr_unroll
    import randomizer_pkg::*;
#(
    parameter int                LFSR_W = 15,
    parameter logic [LFSR_W-1:0] TAPS   = LFSR_W'(PN15_TAPS),
    parameter int                DATA_W = 8
) (
    input  logic [LFSR_W-1:0] state_in,
    output logic [LFSR_W-1:0] state_out,
    output logic [DATA_W-1:0] pn
);

    logic [LFSR_W-1:0] step_state;

    always_comb begin
        step_state = state_in;
        pn         = '0;
        for (int i = 0; i < DATA_W; i++) begin
            step_state = LFSR_W'(lfsr_step(32'(step_state), 32'(TAPS), LFSR_W));
            pn[i]      = step_state[LFSR_W-1];
        end
        state_out = step_state;
    end

endmodule

// File: rtl/randomizer_par.sv
// Parallel additive LFSR scrambler/descrambler with a one-entry valid/ready output register.
// Holds seed_reg, the running LFSR, the sticky lockup flag and the output beat.
module randomizer_par
    import randomizer_pkg::*;
#(
    parameter int                LFSR_W        = 15,
    parameter logic [LFSR_W-1:0] TAPS          = LFSR_W'(PN15_TAPS),
    parameter int                DATA_W        = 8,
    parameter logic [LFSR_W-1:0] SEED_RST      = LFSR_W'(SEED_DVB),
    parameter bit                RELOAD_ON_SOF = 1'b1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              seed_load,
    input  logic [LFSR_W-1:0] seed,
    input  logic              bypass,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic              in_sof,
    input  logic [DATA_W-1:0] in_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic              out_sof,
    output logic [DATA_W-1:0] out_data,
    output logic              lockup
);

    logic [LFSR_W-1:0] lfsr;
    logic [LFSR_W-1:0] seed_reg;
    logic [LFSR_W-1:0] start_state;
    logic [LFSR_W-1:0] adv_state;
    logic [LFSR_W-1:0] lfsr_next;
    logic [DATA_W-1:0] pn;
    logic              accept;

    assign in_ready = !out_valid || out_ready;
    assign accept   = in_valid && in_ready;

    // A start-of-frame beat is scrambled from the seed, so every frame sees the same PN prefix.
    always_comb begin
        start_state = lfsr;
        if (RELOAD_ON_SOF && in_sof) begin
            start_state = seed_reg;
        end
    end

    lfsr_unroll #(
        .LFSR_W (LFSR_W),
        .TAPS   (TAPS),
        .DATA_W (DATA_W)
    ) u_unroll (
        .state_in  (start_state),
        .state_out (adv_state),
        .pn        (pn)
    );

    // A seed load wins over the advance, while the beat accepted alongside it still used the old state.
    always_comb begin
        lfsr_next = lfsr;
        if (seed_load) begin
            lfsr_next = seed;
        end else if (accept && !bypass) begin
            lfsr_next = adv_state;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            lfsr     <= SEED_RST;
            seed_reg <= SEED_RST;
            lockup   <= 1'b0;
        end else begin
            lfsr <= lfsr_next;
            if (seed_load) begin
                seed_reg <= seed;
                lockup   <= (seed == '0);
            end else if (lfsr_next == '0) begin
                lockup <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            out_valid <= 1'b0;
            out_sof   <= 1'b0;
            out_data  <= '0;
        end else if (accept) begin
            out_valid <= 1'b1;
            out_sof   <= in_sof;
            out_data  <= bypass ? in_data : (in_data ^ pn);
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_randomizer_par.sv
// Scoreboard bench for randomizer_par: an 8-bit instance, a 1-bit instance and a chained round-trip pair.
module tb_randomizer_par;

    typedef struct packed {
        logic       sof;
        logic [7:0] data;
    } exp_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset;
    logic        seed_load, bypass, in_valid, in_ready, in_sof;
    logic [14:0] seed;
    logic [7:0]  in_data, out_data;
    logic        out_valid, out_ready, out_sof, lockup;

    logic        d1_seed_load, d1_in_valid, d1_in_ready, d1_out_valid, d1_out_sof, d1_lockup;
    logic [14:0] d1_seed;
    logic [0:0]  d1_in_data, d1_out_data;

    logic        rt_in_valid, rt_in_ready, rt_in_sof, rt_out_valid, rt_out_ready, rt_out_sof;
    logic [7:0]  rt_in_data, rt_out_data, mid_data;
    logic        mid_valid, mid_ready, mid_sof, scr_lockup, dsc_lockup;

    int          n_checks = 0;
    int          n_fail = 0;
    exp_t        sb_q[$];
    exp_t        rt_q[$];
    exp_t        mon_e;
    exp_t        rt_e;
    logic [14:0] m_lfsr, m_seed;
    logic        m_lock, m_ov;
    logic [7:0]  exp_o, held, frame_first;
    logic [14:0] exp_ns;
    logic [15:0] stream;
    int          sent, rcvd, cyc;

    randomizer_par dut (
        .clk(clk), .reset(reset), .seed_load(seed_load), .seed(seed), .bypass(bypass),
        .in_valid(in_valid), .in_ready(in_ready), .in_sof(in_sof), .in_data(in_data),
        .out_valid(out_valid), .out_ready(out_ready), .out_sof(out_sof), .out_data(out_data),
        .lockup(lockup)
    );

    randomizer_par #(.DATA_W(1)) dut1 (
        .clk(clk), .reset(reset), .seed_load(d1_seed_load), .seed(d1_seed), .bypass(1'b0),
        .in_valid(d1_in_valid), .in_ready(d1_in_ready), .in_sof(1'b0), .in_data(d1_in_data),
        .out_valid(d1_out_valid), .out_ready(1'b1), .out_sof(d1_out_sof), .out_data(d1_out_data),
        .lockup(d1_lockup)
    );

    randomizer_par scr (
        .clk(clk), .reset(reset), .seed_load(1'b0), .seed(15'h0000), .bypass(1'b0),
        .in_valid(rt_in_valid), .in_ready(rt_in_ready), .in_sof(rt_in_sof), .in_data(rt_in_data),
        .out_valid(mid_valid), .out_ready(mid_ready), .out_sof(mid_sof), .out_data(mid_data),
        .lockup(scr_lockup)
    );

    randomizer_par dsc (
        .clk(clk), .reset(reset), .seed_load(1'b0), .seed(15'h0000), .bypass(1'b0),
        .in_valid(mid_valid), .in_ready(mid_ready), .in_sof(mid_sof), .in_data(mid_data),
        .out_valid(rt_out_valid), .out_ready(rt_out_ready), .out_sof(rt_out_sof), .out_data(rt_out_data),
        .lockup(dsc_lockup)
    );

    task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("[TB] FAIL %s: observed 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    // Reference PN15 scrambler: fb = s[0]^s[1], shifted in at the top, bit 0 first in time.
    task automatic model_beat(input logic [14:0] st, input logic [7:0] d,
                              output logic [7:0] o, output logic [14:0] ns);
        logic fb;
        ns = st;
        o  = '0;
        for (int i = 0; i < 8; i++) begin
            fb   = ^(ns & 15'h0003);
            o[i] = d[i] ^ fb;
            ns   = {fb, ns[14:1]};
        end
    endtask

    task automatic model_reset();
        m_lfsr = 15'h4A80;
        m_seed = 15'h4A80;
        m_lock = 1'b0;
        m_ov   = 1'b0;
    endtask

    // Drives one cycle on the 8-bit instance, predicts handshake and output, and updates the model.
    task automatic applyStimulus(input logic v, input logic sof, input logic byp, input logic ld,
                                 input logic rdy, input logic [7:0] d, input logic [14:0] sd);
        logic        acc;
        logic [7:0]  o;
        logic [14:0] ns;
        in_valid  = v;
        in_sof    = sof;
        bypass    = byp;
        seed_load = ld;
        seed      = sd;
        in_data   = d;
        out_ready = rdy;
        @(negedge clk);
        checkOutput("in_ready", 64'(in_ready), 64'(!m_ov || rdy));
        acc = v && (!m_ov || rdy);
        ns  = m_lfsr;
        if (acc) begin
            model_beat(sof ? m_seed : m_lfsr, d, o, ns);
            if (byp) o = d;
            sb_q.push_back(exp_t'({sof, o}));
        end
        if (ld) begin
            m_lfsr = sd;
            m_seed = sd;
            m_lock = (sd == 15'h0000);
        end else if (acc && !byp) begin
            m_lfsr = ns;
            if (ns == 15'h0000) m_lock = 1'b1;
        end
        if (acc) m_ov = 1'b1;
        else if (rdy) m_ov = 1'b0;
        @(posedge clk);
        #1;
        in_valid  = 1'b0;
        seed_load = 1'b0;
        checkOutput("lockup", 64'(lockup), 64'(m_lock));
    endtask

    always @(negedge clk) begin
        if (reset && out_valid && out_ready) begin
            checkOutput("sb_nonempty", 64'(sb_q.size() != 0), 64'(1));
            if (sb_q.size() != 0) begin
                mon_e = sb_q.pop_front();
                checkOutput("sb_data", 64'(out_data), 64'(mon_e.data));
                checkOutput("sb_sof", 64'(out_sof), 64'(mon_e.sof));
            end
        end
    end

    initial begin
        reset = 1'b0;
        seed_load = 1'b0; seed = '0; bypass = 1'b0; in_valid = 1'b0; in_sof = 1'b0;
        in_data = '0; out_ready = 1'b1;
        d1_seed_load = 1'b0; d1_seed = '0; d1_in_valid = 1'b0; d1_in_data = '0;
        rt_in_valid = 1'b0; rt_in_sof = 1'b0; rt_in_data = '0; rt_out_ready = 1'b0;
        model_reset();
        #3;
        checkOutput("rst_out_valid", 64'(out_valid), 64'(0));
        checkOutput("rst_out_data", 64'(out_data), 64'(0));
        checkOutput("rst_out_sof", 64'(out_sof), 64'(0));
        checkOutput("rst_lockup", 64'(lockup), 64'(0));
        checkOutput("rst_in_ready", 64'(in_ready), 64'(1));
        @(posedge clk); #1;
        reset = 1'b1;
        @(posedge clk); #1;

        $display("[TB] reference vector, seed 0001");
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 8'h00, 15'h0001);
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 8'h00, 15'h0000);
        checkOutput("vec_beat0", 64'(out_data), 64'(8'h01));
        checkOutput("vec_latency", 64'(out_valid), 64'(1));
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 8'h00, 15'h0000);
        checkOutput("vec_beat1", 64'(out_data), 64'(8'hC0));

        $display("[TB] frame reload");
        for (int k = 0; k < 6; k++) begin
            applyStimulus(1'b1, (k == 0) || (k == 5), 1'b0, 1'b0, 1'b1, 8'h5A, 15'h0000);
            if (k == 0) frame_first = out_data;
        end
        checkOutput("frame_reload", 64'(out_data), 64'(frame_first));

        $display("[TB] backpressure");
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 8'h33, 15'h0000);
        held = out_data;
        for (int k = 0; k < 3; k++) begin
            applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 8'h44, 15'h0000);
            checkOutput("bp_hold", 64'(out_data), 64'(held));
            checkOutput("bp_valid", 64'(out_valid), 64'(1));
        end
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 8'h44, 15'h0000);
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 8'h45, 15'h0000);

        $display("[TB] seed load with beat");
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 8'h00, 15'h1234);
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 8'h00, 15'h0000);
        model_beat(15'h1234, 8'h00, exp_o, exp_ns);
        checkOutput("seed_new", 64'(out_data), 64'(exp_o));

        $display("[TB] zero seed lockup");
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 8'h00, 15'h0000);
        checkOutput("zero_lockup", 64'(lockup), 64'(1));
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 8'hA5, 15'h0000);
        checkOutput("zero_passthru", 64'(out_data), 64'(8'hA5));
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 8'h00, 15'h0001);
        checkOutput("lockup_clear", 64'(lockup), 64'(0));

        $display("[TB] random traffic");
        for (int k = 0; k < 200; k++) begin
            applyStimulus($urandom_range(0, 3) != 0, $urandom_range(0, 15) == 0,
                          $urandom_range(0, 15) == 0, $urandom_range(0, 31) == 0,
                          $urandom_range(0, 3) != 0, 8'($urandom), 15'($urandom));
        end
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 8'h00, 15'h0000);
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 8'h00, 15'h0000);
        checkOutput("sb_drained", 64'(sb_q.size()), 64'(0));

        $display("[TB] reset mid-stream");
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 8'h77, 15'h0000);
        checkOutput("mid_valid_before", 64'(out_valid), 64'(1));
        #2;
        reset = 1'b0;
        #1;
        checkOutput("mid_rst_valid", 64'(out_valid), 64'(0));
        checkOutput("mid_rst_data", 64'(out_data), 64'(0));
        @(posedge clk); #3;
        reset = 1'b1;
        sb_q.delete();
        model_reset();
        @(posedge clk); #1;
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 8'h00, 15'h0000);
        model_beat(15'h4A80, 8'h00, exp_o, exp_ns);
        checkOutput("post_rst_seed", 64'(out_data), 64'(exp_o));

        $display("[TB] one-bit datapath");
        d1_seed = 15'h0001;
        d1_seed_load = 1'b1;
        @(posedge clk); #1;
        d1_seed_load = 1'b0;
        stream = '0;
        for (int i = 0; i < 16; i++) begin
            d1_in_valid = 1'b1;
            d1_in_data  = 1'b0;
            @(posedge clk); #1;
            stream[i] = d1_out_data[0];
        end
        d1_in_valid = 1'b0;
        checkOutput("w1_valid", 64'(d1_out_valid), 64'(1));
        checkOutput("w1_stream", 64'(stream), 64'(16'hC001));

        $display("[TB] round trip");
        sent = 0; rcvd = 0; cyc = 0;
        while (rcvd < 1000 && cyc < 20000) begin
            rt_in_valid  = (sent < 1000) && ($urandom_range(0, 2) != 0);
            rt_in_data   = 8'($urandom);
            rt_in_sof    = ($urandom_range(0, 15) == 0);
            rt_out_ready = ($urandom_range(0, 2) != 0);
            @(negedge clk);
            if (rt_in_valid && rt_in_ready) begin
                rt_q.push_back(exp_t'({rt_in_sof, rt_in_data}));
                sent++;
            end
            if (rt_out_valid && rt_out_ready) begin
                checkOutput("rt_nonempty", 64'(rt_q.size() != 0), 64'(1));
                if (rt_q.size() != 0) begin
                    rt_e = rt_q.pop_front();
                    checkOutput("rt_data", 64'(rt_out_data), 64'(rt_e.data));
                    checkOutput("rt_sof", 64'(rt_out_sof), 64'(rt_e.sof));
                end
                rcvd++;
            end
            @(posedge clk); #1;
            cyc++;
        end
        rt_in_valid = 1'b0;
        checkOutput("rt_count", 64'(rcvd), 64'(1000));
        checkOutput("rt_leftover", 64'(rt_q.size()), 64'(0));

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
